// File: rtl/tt_prim_sync_filt_if.sv
// tt_prim_sync_filt_if: groups the raw input vector and the conditioned
// outputs (level plus rise/fall pulses) of tt_prim_sync_filt.
// master = the logic that owns the raw inputs and consumes the outputs.
// slave  = the conditioning primitive itself.
interface tt_prim_sync_filt_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;     // asynchronous raw inputs
  logic [WIDTH-1:0] z;     // synchronised, filtered, polarity-corrected level
  logic [WIDTH-1:0] rise;  // one-cycle pulse on z 0->1
  logic [WIDTH-1:0] fall;  // one-cycle pulse on z 1->0

  modport master (
    output a,
    input  z,
    input  rise,
    input  fall
  );

  modport slave (
    input  a,
    output z,
    output rise,
    output fall
  );
endinterface : tt_prim_sync_filt_if

// File: rtl/tt_prim_sync_filt.sv
// tt_prim_sync_filt: per-channel input conditioning.
//   ai = a ^ INV_MASK -> STAGES-deep synchroniser -> consecutive-sample
//   glitch filter (FILT_LEN agreeing samples accept a change) -> level z,
//   plus registered one-cycle rise/fall pulses on z.
// Channels are fully independent.
// Optional feature macro: TT_PRIM_SYNC_EDGE_EN
//   defined   : rise/fall pulse registers are built.
//   undefined : rise/fall are tied to 0, no edge flops; z is unchanged.
module tt_prim_sync_filt #(
  parameter int               WIDTH    = 8,
  parameter int               STAGES   = 2,
  parameter int               FILT_LEN = 4,
  parameter logic [WIDTH-1:0] INV_MASK = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tt_prim_sync_filt_if.slave   bus
);

  // Counter only has to reach FILT_LEN-1; keep at least one bit so the
  // declaration stays legal when FILT_LEN = 1 (counter then stays at 0).
  localparam int             CW      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(FILT_LEN - 1);

  logic [WIDTH-1:0]                 w_ai;
  logic [STAGES-1:0][WIDTH-1:0]     r_sync;
  logic [WIDTH-1:0]                 w_s;
  logic [WIDTH-1:0]                 r_z;
  logic [WIDTH-1:0]                 w_z_next;
  logic [WIDTH-1:0][CW-1:0]         r_cnt;
  logic [WIDTH-1:0][CW-1:0]         w_cnt_next;

  // Polarity correction happens before the first flop so the synchroniser
  // only ever sees the corrected sense.
  assign w_ai = bus.a ^ INV_MASK;
  assign w_s  = r_sync[STAGES-1];

  // Synchroniser shift chain; every stage resets to RST_VAL so no phantom
  // edge travels down the chain after reset release.
  // NOTE: the chain is a handful of flops, not a memory, so resetting every
  // stage is cheap and keeps reset behaviour deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      // NOTE: non-blocking, so each stage captures the previous stage's value
      // from before this edge; blocking here would collapse the chain to one
      // flop.
      r_sync[0] <= w_ai;
      for (int k = 1; k < STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  // Filter next-state: any agreeing sample clears the count; FILT_LEN
  // consecutive differing samples move z to the new value.
  always_comb begin
    // NOTE: defaults first, so every path assigns every bit and no latch
    // is inferred.
    w_z_next   = r_z;
    w_cnt_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_s[i] != r_z[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_z_next[i] = w_s[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Filter state: accepted level and per-channel agreement counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z   <= RST_VAL;
      r_cnt <= '0;
    end else begin
      r_z   <= w_z_next;
      r_cnt <= w_cnt_next;
    end
  end

  assign bus.z = r_z;

`ifdef TT_PRIM_SYNC_EDGE_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  // Edge pulses are registered from the same next-state as z, so a pulse is
  // high exactly in the first cycle z shows its new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= ~r_z &  w_z_next;
      r_fall <=  r_z & ~w_z_next;
    end
  end

  assign bus.rise = r_rise;
  assign bus.fall = r_fall;
`else
  assign bus.rise = '0;
  assign bus.fall = '0;
`endif

endmodule : tt_prim_sync_filt

// File: tb/tb_tt_prim_sync_filt.sv
// tb_tt_prim_sync_filt: scoreboard bench for tt_prim_sync_filt.
// Two instances share clk/rst_n:
//   u_dut_a : RST_VAL=8'hA5, INV_MASK=8'h00 (reset, latency, glitch, mid-reset)
//   u_dut_b : RST_VAL=8'h00, INV_MASK=8'h01 (inversion)
// Expected z/rise/fall per clock edge are derived from the latency rule
// (change appears after edge STAGES+FILT_LEN-1 counted from the first
// sampling edge) and queued before stimulus; each edge pops and compares.
// Honours TT_PRIM_SYNC_EDGE_EN: without it every expected pulse is 0.
`timescale 1ns/1ps
module tb_tt_prim_sync_filt;

  localparam int STAGES   = 2;
  localparam int FILT_LEN = 4;
  localparam int LAT_E    = STAGES + FILT_LEN - 1;  // edge index of change

`ifdef TT_PRIM_SYNC_EDGE_EN
  localparam logic [7:0] EN_MASK = 8'hFF;
`else
  localparam logic [7:0] EN_MASK = 8'h00;
`endif

  typedef struct packed {
    logic [7:0] z;
    logic [7:0] r;
    logic [7:0] f;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  exp_t q_a[$];
  exp_t q_b[$];

  tt_prim_sync_filt_if #(.WIDTH(8)) if_a ();
  tt_prim_sync_filt_if #(.WIDTH(8)) if_b ();

  tt_prim_sync_filt #(
    .WIDTH(8), .STAGES(STAGES), .FILT_LEN(FILT_LEN),
    .INV_MASK(8'h00), .RST_VAL(8'hA5)
  ) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  tt_prim_sync_filt #(
    .WIDTH(8), .STAGES(STAGES), .FILT_LEN(FILT_LEN),
    .INV_MASK(8'h01), .RST_VAL(8'h00)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge (sample/drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue n expected entries: level zo until edge e_at, zn from then on,
  // with the matching pulse only at edge e_at.
  function automatic void plan(input bit sel, input logic [7:0] zo,
                               input logic [7:0] zn, input int e_at,
                               input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.z = (k >= e_at) ? zn : zo;
      e.r = (k == e_at) ? (zn & ~zo & EN_MASK) : 8'h00;
      e.f = (k == e_at) ? (zo & ~zn & EN_MASK) : 8'h00;
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
    end
  endfunction

  // Reset values, quiet release on dut_a, inverted channel rise on dut_b.
  task automatic test_reset();
    exp_t ea, eb;
    rst_n  = 1'b0;
    if_a.a = 8'h00;
    if_b.a = 8'h00;
    repeat (3) tick();
    n_checks++;
    if ({if_a.z, if_a.rise, if_a.fall} !== {8'hA5, 8'h00, 8'h00}) begin
      n_errors++;
      $display("FAIL reset_a z/rise/fall=%h/%h/%h expected a5/00/00",
               if_a.z, if_a.rise, if_a.fall);
    end
    n_checks++;
    if ({if_b.z, if_b.rise, if_b.fall} !== 24'h0) begin
      n_errors++;
      $display("FAIL reset_b z/rise/fall=%h/%h/%h expected 00/00/00",
               if_b.z, if_b.rise, if_b.fall);
    end
    if_a.a = 8'hA5;
    plan(1'b0, 8'hA5, 8'hA5, 0, 10);
    plan(1'b1, 8'h00, 8'h01, LAT_E, 10);
    rst_n = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      n_checks++;
      if ({if_a.z, if_a.rise, if_a.fall} !== ea) begin
        n_errors++;
        $display("FAIL release_a e=%0d z/rise/fall=%h/%h/%h expected %h/%h/%h",
                 e, if_a.z, if_a.rise, if_a.fall, ea.z, ea.r, ea.f);
      end
      n_checks++;
      if ({if_b.z, if_b.rise, if_b.fall} !== eb) begin
        n_errors++;
        $display("FAIL inversion_b e=%0d z/rise/fall=%h/%h/%h expected %h/%h/%h",
                 e, if_b.z, if_b.rise, if_b.fall, eb.z, eb.r, eb.f);
      end
    end
  endtask

  // Channel 0 falls then rises; each change must land exactly at LAT_E.
  task automatic test_latency();
    exp_t ea;
    logic [7:0] seq [2] = '{8'hA4, 8'hA5};
    for (int s = 0; s < 2; s++) begin
      plan(1'b0, if_a.a, seq[s], LAT_E, 10);
      if_a.a = seq[s];
      for (int e = 0; e < 10; e++) begin
        tick();
        ea = q_a.pop_front();
        n_checks++;
        if ({if_a.z, if_a.rise, if_a.fall} !== ea) begin
          n_errors++;
          $display("FAIL latency s=%0d e=%0d z/rise/fall=%h/%h/%h expected %h/%h/%h",
                   s, e, if_a.z, if_a.rise, if_a.fall, ea.z, ea.r, ea.f);
        end
      end
    end
  endtask

  // Channel 3 pulses of FILT_LEN-1 (rejected) and FILT_LEN (accepted) cycles.
  task automatic test_glitch();
    exp_t ea;
    for (int len = FILT_LEN - 1; len <= FILT_LEN; len++) begin
      if (len < FILT_LEN) begin
        plan(1'b0, 8'hA5, 8'hA5, 0, 14);
      end else begin
        plan(1'b0, 8'hA5, 8'hAD, LAT_E, len + LAT_E);
        plan(1'b0, 8'hAD, 8'hA5, 0, 14 - (len + LAT_E));
      end
      if_a.a = 8'hAD;
      for (int e = 0; e < 14; e++) begin
        tick();
        if (e == len - 1) if_a.a = 8'hA5;
        ea = q_a.pop_front();
        n_checks++;
        if ({if_a.z, if_a.rise, if_a.fall} !== ea) begin
          n_errors++;
          $display("FAIL glitch len=%0d e=%0d z/rise/fall=%h/%h/%h expected %h/%h/%h",
                   len, e, if_a.z, if_a.rise, if_a.fall, ea.z, ea.r, ea.f);
        end
      end
    end
  endtask

  // Reset lands two filter samples into a change; the partial count is
  // lost and the full latency applies after release with a != RST_VAL.
  task automatic test_mid_reset();
    exp_t ea, eb;
    plan(1'b0, 8'hA5, 8'hA1, LAT_E, 10);
    plan(1'b0, 8'hA1, 8'hA1, 0, 4);
    if_a.a = 8'hA1;
    for (int e = 0; e < 14; e++) begin
      tick();
      if (e == 9) if_a.a = 8'hA5;
      ea = q_a.pop_front();
      n_checks++;
      if ({if_a.z, if_a.rise, if_a.fall} !== ea) begin
        n_errors++;
        $display("FAIL mid_pre e=%0d z/rise/fall=%h/%h/%h expected %h/%h/%h",
                 e, if_a.z, if_a.rise, if_a.fall, ea.z, ea.r, ea.f);
      end
    end
    rst_n  = 1'b0;
    if_a.a = 8'hA1;
    #1;
    n_checks++;
    if ({if_a.z, if_a.rise, if_a.fall} !== {8'hA5, 8'h00, 8'h00}) begin
      n_errors++;
      $display("FAIL mid_reset_a z/rise/fall=%h/%h/%h expected a5/00/00",
               if_a.z, if_a.rise, if_a.fall);
    end
    n_checks++;
    if ({if_b.z, if_b.rise, if_b.fall} !== 24'h0) begin
      n_errors++;
      $display("FAIL mid_reset_b z/rise/fall=%h/%h/%h expected 00/00/00",
               if_b.z, if_b.rise, if_b.fall);
    end
    repeat (2) tick();
    plan(1'b0, 8'hA5, 8'hA1, LAT_E, 10);
    plan(1'b1, 8'h00, 8'h01, LAT_E, 10);
    rst_n = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      n_checks++;
      if ({if_a.z, if_a.rise, if_a.fall} !== ea) begin
        n_errors++;
        $display("FAIL mid_post_a e=%0d z/rise/fall=%h/%h/%h expected %h/%h/%h",
                 e, if_a.z, if_a.rise, if_a.fall, ea.z, ea.r, ea.f);
      end
      n_checks++;
      if ({if_b.z, if_b.rise, if_b.fall} !== eb) begin
        n_errors++;
        $display("FAIL mid_post_b e=%0d z/rise/fall=%h/%h/%h expected %h/%h/%h",
                 e, if_b.z, if_b.rise, if_b.fall, eb.z, eb.r, eb.f);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_latency();
    test_glitch();
    test_mid_reset();
    n_checks++;
    if ((q_a.size() + q_b.size()) !== 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain left=%0d expected 0", q_a.size() + q_b.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_tt_prim_sync_filt
